// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO with a registered head word.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = head_q;

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    head_d  = head_q;
    // The incoming word becomes head only when nothing older survives this cycle.
    if (do_push && (empty_o || (do_pop && cnt_q == CW'(1))))
      head_d = wdata_i;
    else if (do_pop && cnt_q > CW'(1))
      head_d = mem_q[rptr_d];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin sync, clock glitch filter, frame FSM, timeout, scan-code FIFO.
// Define PS2_BREAK_FILTER_EN to drop break prefixes (F0) and the byte following them.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       KBD_CLK,
  input  logic       KBD_DATA,
  output logic [7:0] dataOut,
  output logic       dataOutValid,
  input  logic       dataOutReady,
  output logic       rxError,
  output logic       overflow
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic           kclk_s1_q, kclk_s2_q, kdat_s1_q, kdat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall;

  ps2_state_e     state_q, state_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           good_d, err_d, push_d;
  logic           push_q, err_q;
  logic [7:0]     pdata_q;
  logic           fifo_full, fifo_empty, pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kclk_s1_q <= 1'b1;
      kclk_s2_q <= 1'b1;
      kdat_s1_q <= 1'b1;
      kdat_s2_q <= 1'b1;
    end else begin
      kclk_s1_q <= KBD_CLK;
      kclk_s2_q <= kclk_s1_q;
      kdat_s1_q <= KBD_DATA;
      kdat_s2_q <= kdat_s1_q;
    end
  end

  // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (kclk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = kclk_s2_q;
      else                                fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmr_d   = tmr_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      tmr_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!kdat_s2_q) begin
            bcnt_d  = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_d = {kdat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = kdat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (kdat_s2_q && (^{shift_q, par_q})) good_d = 1'b1;
          else                                  err_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
    if (state_d == ST_IDLE) tmr_d = '0;
  end

`ifdef PS2_BREAK_FILTER_EN
  logic brk_q, brk_d;

  always_comb begin
    brk_d  = brk_q;
    push_d = 1'b0;
    if (err_d) begin
      brk_d = 1'b0;
    end else if (good_d) begin
      if (brk_q)                        brk_d  = 1'b0;
      else if (shift_q == PS2_BREAK)    brk_d  = 1'b1;
      else                              push_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) brk_q <= 1'b0;
    else         brk_q <= brk_d;
  end
`else
  assign push_d = good_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmr_q   <= '0;
      push_q  <= 1'b0;
      pdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmr_q   <= tmr_d;
      push_q  <= push_d;
      pdata_q <= shift_q;
      err_q   <= err_d;
    end
  end

  assign pop          = ~fifo_empty & dataOutReady;
  assign dataOutValid = ~fifo_empty;
  assign rxError      = err_q;
  assign overflow     = push_q & fifo_full & ~pop;

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_q),
    .wdata_i (pdata_q),
    .pop_i   (pop),
    .head_o  (dataOut),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus random frames against a queue model.
module tb_ps2_kbd_rx;

  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 4;
  localparam int H     = 20;
  localparam int W     = 2 + FL + 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       KBD_CLK = 1'b1;
  logic       KBD_DATA = 1'b1;
  logic       dataOutReady = 1'b0;
  logic [7:0] dataOut;
  logic       dataOutValid, rxError, overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] mq[$];
  logic [7:0] popped[$];
  bit  brk = 1'b0;
  bit  settle = 1'b0;
  bit  vprev = 1'b0;
  int  mode = 0;
  int  exp_err = 0, exp_ovf = 0, seen_err = 0, seen_ovf = 0;
  int  err_cyc = 0, fall_cyc = 0, vrise_cyc = 0;

  ps2_kbd_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .KBD_CLK      (KBD_CLK),
    .KBD_DATA     (KBD_DATA),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .dataOutReady (dataOutReady),
    .rxError      (rxError),
    .overflow     (overflow)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: outputs against the model queue, plus the consumer side of the handshake.
  always @(negedge clk) begin
    bit r;
    if (resetn) begin
      if (rxError) begin
        seen_err++;
        err_cyc = cyc;
      end
      if (overflow) seen_ovf++;
      if (dataOutValid && !vprev) vrise_cyc = cyc;
      vprev = dataOutValid;
      if (!settle) begin
        chk("valid", {31'd0, dataOutValid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) chk("head", {24'd0, dataOut}, {24'd0, mq[0]});
      end
      if (settle || mode == 0) r = 1'b0;
      else if (mode == 1)      r = 1'b1;
      else                     r = 1'($urandom_range(0, 1));
      dataOutReady = r;
      if (dataOutValid && r && mq.size() != 0) begin
        popped.push_back(dataOut);
        void'(mq.pop_front());
      end
    end
  end

  task automatic finish_frame(input logic [7:0] b, input bit good);
    bit push;
    push = good;
    if (good) begin
`ifdef PS2_BREAK_FILTER_EN
      if (brk) begin
        brk  = 1'b0;
        push = 1'b0;
      end else if (b == 8'hF0) begin
        brk  = 1'b1;
        push = 1'b0;
      end
`endif
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(b);
        else                   exp_ovf++;
      end
    end else begin
      exp_err++;
      brk = 1'b0;
    end
    chk("err_count", seen_err, exp_err);
    chk("ovf_count", seen_ovf, exp_ovf);
    settle = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      KBD_DATA = f[i];
      if (i == 10) settle = 1'b1;
      cycles(H);
      KBD_CLK  = 1'b0;
      fall_cyc = cyc;
      if (i == 10) begin
        cycles(W);
        finish_frame(b, !bad_par && !bad_stop);
        cycles(H - W);
      end else begin
        cycles(H);
      end
      KBD_CLK = 1'b1;
    end
    KBD_DATA = 1'b1;
    cycles(H);
  endtask

  initial begin
    int e0, o0, d, tgt;
    logic [7:0] b;
    logic [7:0] exp6 [$];

    cycles(3);
    chk("rst_dataOut", {24'd0, dataOut}, 32'h00);
    chk("rst_valid", {31'd0, dataOutValid}, 32'd0);
    chk("rst_rxError", {31'd0, rxError}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;
    cycles(5);

    // 1: single good frame and its latency
    mode = 0;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    chk("t1_data", {24'd0, dataOut}, 32'h1C);
    chk("t1_valid", {31'd0, dataOutValid}, 32'd1);
    d = vrise_cyc - fall_cyc;
    chk("t1_latency_in_range", {31'd0, (d >= 1 && d <= 2 + FL + 2)}, 32'd1);
    mode = 1;
    cycles(10);
    chk("t1_drained", {31'd0, dataOutValid}, 32'd0);

    // 2: parity error, then stop error
    mode = 0;
    e0 = seen_err;
    send_frame(8'h00, 1'b1, 1'b0, 11);
    chk("t2_par_err", seen_err - e0, 32'd1);
    chk("t2_par_valid", {31'd0, dataOutValid}, 32'd0);
    send_frame(8'h00, 1'b0, 1'b1, 11);
    chk("t2_stop_err", seen_err - e0, 32'd2);
    chk("t2_stop_valid", {31'd0, dataOutValid}, 32'd0);

    // 3: overflow with a stalled consumer, then in-order drain
    popped.delete();
    o0 = seen_ovf;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 11);
    chk("t3_ovf", seen_ovf - o0, 32'd1);
    mode = 1;
    cycles(12);
    chk("t3_npop", popped.size(), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("t3_pop_order", {24'd0, popped[i]}, i + 1);
    chk("t3_valid_end", {31'd0, dataOutValid}, 32'd0);

    // 4: timeout after a partial frame, then recovery
    e0 = seen_err;
    send_frame(8'h2A, 1'b0, 1'b0, 5);
    tgt = fall_cyc + TO + 2 + FL - 2;
    while (cyc < tgt) cycles(1);
    chk("t4_no_early_err", seen_err - e0, 32'd0);
    for (int k = 0; k < 10 && seen_err == e0; k++) cycles(1);
    chk("t4_timeout_err", seen_err - e0, 32'd1);
    d = err_cyc - fall_cyc;
    chk("t4_timeout_time", {31'd0, (d >= TO + 2 + FL - 1 && d <= TO + 2 + FL + 1)}, 32'd1);
    exp_err++;
    brk = 1'b0;
    mode = 0;
    send_frame(8'h2A, 1'b0, 1'b0, 11);
    chk("t4_data", {24'd0, dataOut}, 32'h2A);
    mode = 1;
    cycles(10);

    // 5: short clock glitch while idle, then asynchronous reset mid-frame
    mode = 0;
    e0 = seen_err;
    KBD_DATA = 1'b0;
    KBD_CLK  = 1'b0;
    cycles(FL - 1);
    KBD_CLK = 1'b1;
    cycles(5);
    KBD_DATA = 1'b1;
    cycles(H);
    chk("t5_glitch_valid", {31'd0, dataOutValid}, 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 11);
    chk("t5_glitch_err", seen_err - e0, 32'd0);
    chk("t5_after_glitch", {24'd0, dataOut}, 32'h55);
    send_frame(8'h77, 1'b0, 1'b0, 4);
    chk("t5_pre_rst_valid", {31'd0, dataOutValid}, 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk("t5_rst_dataOut", {24'd0, dataOut}, 32'h00);
    chk("t5_rst_valid", {31'd0, dataOutValid}, 32'd0);
    chk("t5_rst_rxError", {31'd0, rxError}, 32'd0);
    chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    mq.delete();
    brk = 1'b0;
    vprev = 1'b0;
    cycles(3);
    resetn = 1'b1;
    cycles(TO + 20);
    chk("t5_post_rst_err", seen_err - e0, 32'd0);
    chk("t5_post_rst_valid", {31'd0, dataOutValid}, 32'd0);

    // 6: break-code handling
    popped.delete();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    mode = 1;
    cycles(12);
`ifdef PS2_BREAK_FILTER_EN
    exp6 = '{8'h1C};
`else
    exp6 = '{8'h1C, 8'hF0, 8'h1C};
`endif
    chk("t6_npop", popped.size(), exp6.size());
    for (int i = 0; i < exp6.size() && i < popped.size(); i++)
      chk("t6_pop", {24'd0, popped[i]}, {24'd0, exp6[i]});

    // Random frames with random consumer stalls
    for (int n = 0; n < 30; n++) begin
      int kind;
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hE0;
      kind = $urandom_range(0, 9);
      mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      send_frame(b, kind == 0, kind == 1, 11);
    end
    mode = 1;
    cycles(20);
    chk("rand_final_valid", {31'd0, dataOutValid}, 32'd0);
    chk("rand_final_model_empty", mq.size(), 32'd0);
    chk("rand_final_err", seen_err, exp_err);
    chk("rand_final_ovf", seen_ovf, exp_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 80000);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
